// File: rtl/inc_share_arb.sv
// Round-robin arbiter sharing one W-bit "+1" incrementer among NREQ requesters.
// Optional macro INC_SAT_EN selects a saturating increment instead of wrapping.
//
// state | meaning
// IDLE  | arbitrate; grant the first req at or after ptr and latch its operand
// EXEC  | grant pulse visible; increment the latched operand
// DONE  | done pulse visible with result/ovf/done_id; return to IDLE next edge
module inc_share_arb #(
   parameter int NREQ = 4,
   parameter int W    = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] opnd,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [W-1:0]      result,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  id_q;
   logic [W-1:0]    op_q;

   logic            any_req;
   logic [IDW-1:0]  win;
   logic [IDW-1:0]  win_nxt;
   logic [NREQ-1:0] win_onehot;
   logic [W-1:0]    win_op;
   logic [W:0]      sum_w;

   assign any_req = |req;
   assign busy    = (state_q != IDLE);
   assign sum_w   = {1'b0, op_q} + (W+1)'(1);

   // Rotating priority scan starting at ptr, wrapping at NREQ.
   always_comb begin
      logic             found;
      logic [IDW:0]     idx_w;
      logic [IDW-1:0]   idx;
      found = 1'b0;
      win   = '0;
      idx_w = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
         if (idx_w >= (IDW+1)'(NREQ))
            idx_w = idx_w - (IDW+1)'(NREQ);
         idx = idx_w[IDW-1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      logic [IDW:0] nxt_w;
      nxt_w = {1'b0, win} + (IDW+1)'(1);
      if (nxt_w >= (IDW+1)'(NREQ))
         nxt_w = '0;
      win_nxt = nxt_w[IDW-1:0];
   end

   always_comb begin
      win_onehot = '0;
      win_op     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            win_onehot[i] = 1'b1;
            win_op        = opnd[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= '0;
         gnt     <= '0;
         done    <= 1'b0;
         done_id <= '0;
         result  <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  gnt   <= win_onehot;
                  op_q  <= win_op;
                  id_q  <= win;
                  ptr_q <= win_nxt;
               end
            end
            EXEC: begin
               gnt     <= '0;
               done    <= 1'b1;
               done_id <= id_q;
`ifdef INC_SAT_EN
               if (&op_q) begin
                  result <= '1;
                  ovf    <= 1'b1;
               end else begin
                  {ovf, result} <= sum_w;
               end
`else
               {ovf, result} <= sum_w;
`endif
            end
            DONE: begin
               done <= 1'b0;
            end
            default: begin
               gnt  <= '0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/inc_share_arb.md
# inc_share_arb

Round-robin arbiter and sequencer that shares one W-bit "+1" increment unit among NREQ requesters in the paper processor datapath. Each requester presents a register value and a request. The block grants one requester, captures its operand and runs the increment. It then returns the incremented value with a carry-out (overflow) status, tagged with the requester index. It sits between the register-update logic and the single shared incrementer, so several registers can count with one adder.

## Interface

Parameters:
- NREQ, default 4: number of requesters, legal range 2..8.
- W, default 2: operand/result width in bits.
- IDW, default $clog2(NREQ): width of the requester index.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req, input, NREQ: level request per requester.
- opnd, input, NREQ*W: operand of requester i at bits [i*W +: W]; must be stable while req[i]=1.
- gnt, output, NREQ: one-hot grant pulse, registered.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle completion pulse.
- done_id, output, IDW: index of the completed requester.
- result, output, W: incremented value.
- ovf, output, 1: carry-out of the increment, or saturation hit when saturation is compiled in.

## Operation

- FSM has three states: IDLE, EXEC, DONE.
  - IDLE -> EXEC when |req=1.
  - EXEC -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Arbitration is evaluated only in IDLE.
  - Winner is the first asserted req at or after index ptr, scanning upward and wrapping from NREQ-1 to 0.
  - On grant, ptr <= winner+1 mod NREQ.
- On the IDLE->EXEC edge:
  - gnt[winner]<=1.
  - The winner's operand is latched into op_q and its index into id_q.
- On the EXEC->DONE edge:
  - gnt<=0.
  - {ovf,result} <= op_q + 1, computed in W+1 bits.
  - done_id<=id_q and done<=1.
- On the DONE->IDLE edge: done<=0.
- result, ovf and done_id hold their values until the next done pulse.
- Arithmetic is mod 2^W. ovf=1 exactly when op_q is all-ones; for W=2, 3 -> result 0, ovf 1.
- req and opnd are ignored in EXEC and DONE.
  - A requester must drop req before the DONE->IDLE edge, otherwise it is treated as a new request.
  - A req withdrawn while the FSM is in IDLE and before the edge that samples it is simply never granted.
- Simultaneous requests: exactly one is granted per transaction and the others wait. With all requesters asserting continuously, grants rotate 0,1,…,NREQ-1,0.
- Reset, at any time including mid-transaction:
  - state=IDLE, ptr=0.
  - gnt=0, busy=0, done=0, done_id=0, result=0, ovf=0.
  - The in-flight operation is discarded and no done pulse is produced.

## Timing

- Request sampled at edge E0; gnt is high during the cycle after E0.
- done is high during the cycle after E1, which is one cycle after gnt.
- Earliest next grant is at E3. Peak throughput is one increment per 3 cycles.
- busy is high from after E0 through the DONE cycle; it is low again after E2.
- All outputs are registered; there is no combinational path from req/opnd to any output.
- opnd is sampled only at the grant edge; later changes do not affect result.

## Configuration

- INC_SAT_EN:
  - Defined: saturating increment. An all-ones operand yields result = all-ones and ovf=1.
  - Undefined: wrapping increment. An all-ones operand yields result=0 and ovf=1.
  - Non-overflow cases are identical in both builds.

## Test plan

- Reset, then req=4'b0001 with opnd0=2'd1:
  - gnt=0001 one cycle after the sample.
  - Next cycle: done=1, done_id=0, result=2, ovf=0.
- req0 with opnd0=2'd3:
  - Without INC_SAT_EN: result=0, ovf=1.
  - With INC_SAT_EN: result=3, ovf=1.
- req=4'b1111 held continuously with distinct operands:
  - Grant order 0,1,2,3,0; one grant every 3 cycles.
  - Each done_id matches the preceding gnt.
- ptr=2 after a grant to requester 1, then req=4'b0011:
  - Requester 0 is granted, by wrap-around, before requester 1.
- Change opnd and raise another req during EXEC:
  - result reflects the operand latched at the grant.
  - The new req is granted only after return to IDLE.
- Assert rst_n=0 during EXEC:
  - All outputs are 0 immediately and no done pulse occurs.
  - After release, req3 is granted normally with ptr=0 behaviour.
